// File: rtl/sd_cmd_ctrl_if.sv
// -----------------------------------------------------------------------------
// sd_cmd_ctrl_if
//   Command request/response bundle between a command issuer (sd_reader or the
//   sector writer) and the sd_cmd_ctrl CMD-line engine.
//
//   start    issuer -> engine  one-cycle request, honoured only while busy=0
//   precnt   issuer -> engine  SDCLK cycles of idle-high CMD before the frame
//   cmd      issuer -> engine  command index
//   arg      issuer -> engine  command argument
//   busy     engine -> issuer  transaction in progress
//   done     engine -> issuer  one-cycle completion pulse (busy still 1)
//   timeout  engine -> issuer  no response start bit seen; valid with done
//   syntaxe  engine -> issuer  response format/index/CRC error; valid with done
//   resparg  engine -> issuer  response bits [39:8]; valid with done
// -----------------------------------------------------------------------------
interface sd_cmd_ctrl_if;
  logic        start;
  logic [15:0] precnt;
  logic [5:0]  cmd;
  logic [31:0] arg;
  logic        busy;
  logic        done;
  logic        timeout;
  logic        syntaxe;
  logic [31:0] resparg;

  modport master (
    output start, precnt, cmd, arg,
    input  busy, done, timeout, syntaxe, resparg
  );

  modport slave (
    input  start, precnt, cmd, arg,
    output busy, done, timeout, syntaxe, resparg
  );
endinterface

// File: rtl/sd_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// sd_cmd_ctrl
//   SD-bus CMD-line engine plus SDCLK generator. Takes one command at a time,
//   sends the 48-bit frame (start, transmission, index, argument, CRC7, end),
//   then either idles for NORESP_GAP SDCLKs (CMD0) or waits for and receives a
//   48-bit or 136-bit (CMD2) response and reports timeout/syntax status.
//
//   clk       system clock
//   rstn      asynchronous active-low reset
//   clkdiv    SDCLK half-period in clk cycles (0 behaves as 1), applied at wrap
//   req       command handshake (sd_cmd_ctrl_if.slave)
//   sdclk     SD clock to the card
//   sdcmd_o   CMD line output value, changes only on SDCLK falling events
//   sdcmd_oe  CMD line output enable, changes only on SDCLK falling events
//   sdcmd_i   CMD line input, sampled only on SDCLK rising events
// -----------------------------------------------------------------------------
module sd_cmd_ctrl #(
  parameter int unsigned RESP_TIMEOUT = 250,
  parameter int unsigned NORESP_GAP   = 8
) (
  input  logic           clk,
  input  logic           rstn,
  input  logic [15:0]    clkdiv,
  sd_cmd_ctrl_if.slave   req,
  output logic           sdclk,
  output logic           sdcmd_o,
  output logic           sdcmd_oe,
  input  logic           sdcmd_i
);

  localparam logic [15:0] TMO_LAST = 16'(RESP_TIMEOUT - 1);
  localparam logic [15:0] GAP_LAST = 16'(NORESP_GAP - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_TX,
    S_GAP,
    S_WAIT,
    S_RX,
    S_DONE
  } state_e;

  // CRC7, polynomial x^7 + x^3 + 1, zero seed, MSB first.
  function automatic logic [6:0] crc7(input logic [39:0] bits);
    logic [6:0] c;
    logic       fb;
    c = 7'd0;
    for (int i = 39; i >= 0; i--) begin
      fb = bits[i] ^ c[6];
      c  = {c[5:0], 1'b0} ^ (fb ? 7'h09 : 7'h00);
    end
    return c;
  endfunction

  // ---------------------------------------------------------------------------
  // SDCLK generator. The divider is captured at each wrap so a new clkdiv only
  // affects the following half-period.
  // ---------------------------------------------------------------------------
  logic [15:0] div_q;
  logic [15:0] div_cnt_q;
  logic [15:0] div_eff;
  logic        sdclk_q;
  logic        wrap;
  logic        fall_ev;
  logic        rise_ev;

  assign div_eff = (div_q == 16'd0) ? 16'd1 : div_q;
  assign wrap    = (div_cnt_q == div_eff - 16'd1);
  assign fall_ev = wrap &  sdclk_q;
  assign rise_ev = wrap & ~sdclk_q;

  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of its peers, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_q     <= 16'd0;
      div_cnt_q <= 16'd0;
      sdclk_q   <= 1'b0;
    end else if (wrap) begin
      div_cnt_q <= 16'd0;
      sdclk_q   <= ~sdclk_q;
      div_q     <= clkdiv;
    end else begin
      div_cnt_q <= div_cnt_q + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Command FSM and registered outputs
  // ---------------------------------------------------------------------------
  state_e      state_q;
  logic [15:0] cnt_q;        // precnt / bit / gap / wait counter, per state
  logic [15:0] precnt_q;
  logic [5:0]  cmd_q;
  logic [47:0] frame_q;      // outgoing frame, MSB is the next bit to drive
  logic [47:0] rx_q;         // last 48 response bits received
  logic        trans_q;      // response transmission bit (second bit)
  logic        busy_q;
  logic        done_q;
  logic        timeout_q;
  logic        syntaxe_q;
  logic [31:0] resparg_q;
  logic        oe_q;
  logic        o_q;

  logic [47:0] rx_next;
  logic        rx_bad;
  logic [15:0] rx_last;

  // NOTE: every always_comb output gets a default before any conditional
  // update, so no path can leave it unassigned and infer a latch.
  always_comb begin
    rx_next = {rx_q[46:0], sdcmd_i};
    rx_last = (cmd_q == 6'd2) ? 16'd135 : 16'd47;
    rx_bad  = ~rx_next[0] | trans_q;
    // R3 carries all-ones index/CRC and R2 has its own inner CRC: neither is
    // checked here.
    if (cmd_q != 6'd2 && cmd_q != 6'd41) begin
      rx_bad = rx_bad | (rx_next[45:40] != cmd_q)
                      | (crc7(rx_next[47:8]) != rx_next[7:1]);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 16'd0;
      precnt_q  <= 16'd0;
      cmd_q     <= 6'd0;
      frame_q   <= 48'd0;
      rx_q      <= 48'd0;
      trans_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      timeout_q <= 1'b0;
      syntaxe_q <= 1'b0;
      resparg_q <= 32'd0;
      oe_q      <= 1'b0;
      o_q       <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req.start) begin
            busy_q   <= 1'b1;
            cmd_q    <= req.cmd;
            precnt_q <= req.precnt;
            frame_q  <= {2'b01, req.cmd, req.arg,
                         crc7({2'b01, req.cmd, req.arg}), 1'b1};
            cnt_q    <= 16'd0;
            state_q  <= S_PRE;
          end
        end

        S_PRE: begin
          if (fall_ev) begin
            oe_q <= 1'b1;
            if (cnt_q == precnt_q) begin
              o_q     <= frame_q[47];
              frame_q <= {frame_q[46:0], 1'b1};
              cnt_q   <= 16'd1;
              state_q <= S_TX;
            end else begin
              o_q   <= 1'b1;
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end

        // cnt_q counts bits already driven; the end bit gets a full SDCLK
        // before the line is released.
        S_TX: begin
          if (fall_ev) begin
            if (cnt_q == 16'd48) begin
              oe_q    <= 1'b0;
              o_q     <= 1'b1;
              cnt_q   <= 16'd0;
              state_q <= (cmd_q == 6'd0) ? S_GAP : S_WAIT;
            end else begin
              o_q     <= frame_q[47];
              frame_q <= {frame_q[46:0], 1'b1};
              cnt_q   <= cnt_q + 16'd1;
            end
          end
        end

        S_GAP: begin
          if (fall_ev) begin
            if (cnt_q == GAP_LAST) begin
              done_q    <= 1'b1;
              timeout_q <= 1'b0;
              syntaxe_q <= 1'b0;
              resparg_q <= 32'd0;
              state_q   <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end

        // The first rise after the line is released is already sampled here,
        // so a card answering with zero Ncr is caught.
        S_WAIT: begin
          if (rise_ev) begin
            if (!sdcmd_i) begin
              rx_q    <= rx_next;
              cnt_q   <= 16'd1;
              state_q <= S_RX;
            end else if (cnt_q == TMO_LAST) begin
              done_q    <= 1'b1;
              timeout_q <= 1'b1;
              syntaxe_q <= 1'b0;
              resparg_q <= 32'd0;
              state_q   <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end

        S_RX: begin
          if (rise_ev) begin
            rx_q <= rx_next;
            if (cnt_q == 16'd1) begin
              trans_q <= sdcmd_i;
            end
            if (cnt_q == rx_last) begin
              done_q    <= 1'b1;
              timeout_q <= 1'b0;
              syntaxe_q <= rx_bad;
              resparg_q <= (cmd_q == 6'd2) ? 32'd0 : rx_next[39:8];
              state_q   <= S_DONE;
            end else begin
              cnt_q <= cnt_q + 16'd1;
            end
          end
        end

        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end

        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req.busy    = busy_q;
  assign req.done    = done_q;
  assign req.timeout = timeout_q;
  assign req.syntaxe = syntaxe_q;
  assign req.resparg = resparg_q;
  assign sdclk       = sdclk_q;
  assign sdcmd_o     = o_q;
  assign sdcmd_oe    = oe_q;

endmodule

// File: tb/tb_sd_cmd_ctrl.sv
// -----------------------------------------------------------------------------
// tb_sd_cmd_ctrl
//   Bench for sd_cmd_ctrl. A driver task issues commands, watches the CMD line
//   to capture the outgoing frame and plays an SD card that answers after a
//   chosen Ncr. Expected completions are queued when a command is issued; an
//   independent monitor pops one entry per done pulse and compares.
// -----------------------------------------------------------------------------
module tb_sd_cmd_ctrl;

  localparam int RESP_TIMEOUT = 250;
  localparam int NORESP_GAP   = 8;

  typedef struct packed {
    logic        to;
    logic        syn;
    logic [31:0] ra;
  } exp_t;

  logic        clk;
  logic        rstn;
  logic [15:0] clkdiv;
  logic        sdclk;
  logic        sdcmd_o;
  logic        sdcmd_oe;
  logic        sdcmd_i;

  sd_cmd_ctrl_if bus ();

  sd_cmd_ctrl #(
    .RESP_TIMEOUT (RESP_TIMEOUT),
    .NORESP_GAP   (NORESP_GAP)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .clkdiv   (clkdiv),
    .req      (bus),
    .sdclk    (sdclk),
    .sdcmd_o  (sdcmd_o),
    .sdcmd_oe (sdcmd_oe),
    .sdcmd_i  (sdcmd_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CRC7 as the remainder of msg(x) * x^7 modulo x^7 + x^3 + 1 (long division).
  function automatic logic [6:0] ref_crc7(input logic [39:0] msg);
    logic [46:0] r;
    r = {msg, 7'd0};
    for (int i = 46; i >= 7; i--) begin
      if (r[i]) r[i -: 8] = r[i -: 8] ^ 8'h89;
    end
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [5:0] c, input logic [31:0] a);
    return {2'b01, c, a, ref_crc7({2'b01, c, a}), 1'b1};
  endfunction

  // Expected status for a received response of len bits held in r[len-1:0].
  function automatic exp_t model_resp(input logic [5:0] c, input logic [135:0] r, input int len);
    exp_t e;
    e.to  = 1'b0;
    e.ra  = (c == 6'd2) ? 32'd0 : r[39:8];
    e.syn = (r[len-2] != 1'b0) || (r[0] != 1'b1);
    if (c != 6'd2 && c != 6'd41)
      e.syn = e.syn || (r[45:40] != c) || (ref_crc7(r[47:8]) != r[7:1]);
    return e;
  endfunction

  function automatic exp_t mk_exp(input logic to, input logic syn, input logic [31:0] ra);
    exp_t e;
    e.to  = to;
    e.syn = syn;
    e.ra  = ra;
    return e;
  endfunction

  task automatic check_reset_values(input string tag);
    check({tag, "_busy"},    64'(bus.busy),    64'd0);
    check({tag, "_done"},    64'(bus.done),    64'd0);
    check({tag, "_timeout"}, 64'(bus.timeout), 64'd0);
    check({tag, "_syntaxe"}, 64'(bus.syntaxe), 64'd0);
    check({tag, "_resparg"}, 64'(bus.resparg), 64'd0);
    check({tag, "_sdclk"},   64'(sdclk),       64'd0);
    check({tag, "_oe"},      64'(sdcmd_oe),    64'd0);
    check({tag, "_o"},       64'(sdcmd_o),     64'd1);
  endtask

  // Issue one command, capture and check the frame, play the card, and return
  // at done (or at reset if abort is set).
  task automatic run_cmd(input logic [5:0] c, input logic [31:0] a, input logic [15:0] pc,
                         input logic [47:0] exp_frame, input bit silent,
                         input logic [135:0] reply, input int rlen, input int ncr,
                         input bit inject, input bit abort);
    int          ones, nbits, rises, falls, sent, wait_f, n;
    logic [47:0] fr;
    bit          in_frame, oe_seen, oe_off, got_done, inj_pend, inj_done;
    logic        prev, rose, fell;
    ones = 0; nbits = 0; rises = 0; falls = 0; sent = 0; wait_f = 0;
    fr = '0;
    in_frame = 0; oe_seen = 0; oe_off = 0; got_done = 0; inj_pend = 0; inj_done = 0;
    n = 0;
    while (bus.busy && n < 1000) begin
      tick();
      n++;
    end
    @(negedge clk);
    bus.start  = 1'b1;
    bus.cmd    = c;
    bus.arg    = a;
    bus.precnt = pc;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cmd    = 6'($urandom);
    bus.arg    = $urandom;
    bus.precnt = 16'($urandom);
    prev = sdclk;
    for (n = 0; n < 20000 && !got_done; n++) begin
      tick();
      if (inj_pend) begin
        bus.start = 1'b0;
        inj_pend  = 0;
      end
      rose = !prev && sdclk;
      fell = prev && !sdclk;
      prev = sdclk;
      if (oe_off) begin
        if (rose) rises++;
        if (fell) falls++;
      end
      if (!oe_off && rose && sdcmd_oe) begin
        oe_seen = 1;
        if (!in_frame) begin
          if (sdcmd_o) ones++;
          else begin
            in_frame = 1;
            fr       = '0;
            nbits    = 1;
          end
        end else begin
          fr = {fr[46:0], sdcmd_o};
          nbits++;
        end
        if (inject && !inj_done && nbits == 10) begin
          bus.start = 1'b1;
          bus.cmd   = 6'd55;
          inj_pend  = 1;
          inj_done  = 1;
        end
        if (abort && nbits == 20) begin
          #2;
          rstn = 1'b0;
          #1;
          check_reset_values("abort");
          return;
        end
      end
      if (!oe_off && oe_seen && !sdcmd_oe) begin
        oe_off = 1;
        check("precnt_len", 64'(ones), 64'(pc));
        check("frame_len", 64'(nbits), 64'd48);
        check("frame", 64'(fr), 64'(exp_frame));
        wait_f = ncr;
      end
      if (oe_off && fell && !silent) begin
        if (wait_f > 0) wait_f--;
        else if (sent < rlen) begin
          sdcmd_i = reply[rlen-1-sent];
          sent++;
        end else sdcmd_i = 1'b1;
      end
      if (bus.done === 1'b1) got_done = 1;
    end
    sdcmd_i = 1'b1;
    check("done_seen", 64'(got_done), 64'd1);
    if (got_done && silent && c != 6'd0) check("timeout_rises", 64'(rises), 64'(RESP_TIMEOUT));
    if (got_done && c == 6'd0) check("gap_falls", 64'(falls), 64'(NORESP_GAP));
  endtask

  task automatic ticks_to_edge(output int n);
    logic p;
    p = sdclk;
    n = 0;
    do begin
      tick();
      n++;
    end while (sdclk == p && n < 100);
  endtask

  // Monitor: one expectation per done pulse; done lasts one cycle with busy=1.
  initial begin : monitor
    exp_t e;
    forever begin
      tick();
      if (bus.done === 1'b1) begin
        if (exp_q.size() == 0) begin
          check("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = exp_q.pop_front();
          check("timeout", 64'(bus.timeout), 64'(e.to));
          check("syntaxe", 64'(bus.syntaxe), 64'(e.syn));
          check("resparg", 64'(bus.resparg), 64'(e.ra));
          check("busy_at_done", 64'(bus.busy), 64'd1);
        end
        tick();
        check("done_single", 64'(bus.done), 64'd0);
        check("busy_after_done", 64'(bus.busy), 64'd0);
      end
    end
  end

  initial begin : watchdog
    #950000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : stim
    int          n, h;
    logic [127:0] rnd;
    logic [135:0] rep;
    rstn       = 1'b0;
    clkdiv     = 16'd4;
    sdcmd_i    = 1'b1;
    bus.start  = 1'b0;
    bus.cmd    = 6'd0;
    bus.arg    = 32'd0;
    bus.precnt = 16'd0;
    #23;
    check_reset_values("reset");
    @(negedge clk);
    rstn = 1'b1;

    // SDCLK divider: align to a rising edge with clkdiv=4 in effect.
    ticks_to_edge(n);
    ticks_to_edge(n);
    if (sdclk == 1'b0) ticks_to_edge(n);
    ticks_to_edge(h);
    check("half_lo_div4", 64'(h), 64'd4);
    ticks_to_edge(h);
    check("half_hi_div4", 64'(h), 64'd4);
    tick();
    clkdiv = 16'd2;
    ticks_to_edge(h);
    check("half_old_div", 64'(h), 64'd3);
    ticks_to_edge(h);
    check("half_new_div2", 64'(h), 64'd2);
    clkdiv = 16'd0;
    ticks_to_edge(h);
    check("half_before_div0", 64'(h), 64'd2);
    ticks_to_edge(h);
    check("half_div0", 64'(h), 64'd1);
    clkdiv = 16'd2;
    repeat (4) tick();

    // CMD0: no response, idle gap.
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'd0));
    run_cmd(6'd0, 32'd0, 16'd2, 48'h40_0000_0000_95, 1'b1, '0, 48, 0, 1'b0, 1'b0);

    // CMD8 with a valid R7 arriving with zero Ncr.
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_01AA));
    run_cmd(6'd8, 32'h0000_01AA, 16'd1, 48'h48_0000_01AA_87, 1'b0,
            {88'd0, 48'h08_0000_01AA_13}, 48, 0, 1'b0, 1'b0);

    // CMD8, card silent.
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'd0));
    run_cmd(6'd8, 32'h0000_01AA, 16'd0, 48'h48_0000_01AA_87, 1'b1, '0, 48, 0, 1'b0, 1'b0);

    // CMD8 reply with a CRC bit flipped.
    exp_q.push_back(mk_exp(1'b0, 1'b1, 32'h0000_01AA));
    run_cmd(6'd8, 32'h0000_01AA, 16'd0, 48'h48_0000_01AA_87, 1'b0,
            {88'd0, 48'h08_0000_01AA_13 ^ 48'h4}, 48, 2, 1'b0, 1'b0);

    // CMD41 with an R3 reply.
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'hC0FF_8000));
    run_cmd(6'd41, 32'h4030_0000, 16'd0, ref_frame(6'd41, 32'h4030_0000), 1'b0,
            {88'd0, 48'h3F_C0FF_8000_FF}, 48, 1, 1'b0, 1'b0);

    // CMD2 with a 136-bit R2 reply.
    rnd = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'd0));
    run_cmd(6'd2, 32'd0, 16'd0, ref_frame(6'd2, 32'd0), 1'b0,
            {2'b00, 6'h3F, rnd[126:0], 1'b1}, 136, 3, 1'b0, 1'b0);

    // start pulsed while busy must be ignored.
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_01AA));
    run_cmd(6'd8, 32'h0000_01AA, 16'd0, 48'h48_0000_01AA_87, 1'b0,
            {88'd0, 48'h08_0000_01AA_13}, 48, 0, 1'b1, 1'b0);

    // Randomized commands checked against the reference model.
    for (int t = 0; t < 14; t++) begin
      logic [5:0]  c;
      logic [31:0] a;
      logic [15:0] pc;
      int          rl, kind, pos;
      bit          sil;
      exp_t        e;
      case ($urandom_range(0, 5))
        0:       c = 6'd0;
        1:       c = 6'd2;
        2:       c = 6'd8;
        3:       c = 6'd41;
        4:       c = 6'd17;
        default: c = 6'($urandom);
      endcase
      a      = $urandom;
      pc     = 16'($urandom_range(0, 3));
      clkdiv = 16'($urandom_range(0, 2));
      kind   = $urandom_range(0, 3);
      sil    = (c == 6'd0) || (kind == 1);
      rl     = (c == 6'd2) ? 136 : 48;
      rnd    = {$urandom, $urandom, $urandom, $urandom};
      if (c == 6'd2)
        rep = {2'b00, 6'h3F, rnd[126:0], 1'b1};
      else if (c == 6'd41)
        rep = {88'd0, 2'b00, 6'h3F, rnd[31:0], 7'h7F, 1'b1};
      else
        rep = {88'd0, 2'b00, c, rnd[31:0], ref_crc7({2'b00, c, rnd[31:0]}), 1'b1};
      if (kind == 2) begin
        pos = $urandom_range(0, rl - 2);
        rep[pos] = ~rep[pos];
      end
      if (sil) e = mk_exp(c != 6'd0, 1'b0, 32'd0);
      else     e = model_resp(c, rep, rl);
      exp_q.push_back(e);
      run_cmd(c, a, pc, ref_frame(c, a), sil, rep, rl, $urandom_range(0, 3), 1'b0, 1'b0);
    end

    // Reset in the middle of a frame: no done, everything back to reset values.
    clkdiv = 16'd2;
    exp_q.push_back(mk_exp(1'b1, 1'b0, 32'd0));
    run_cmd(6'd17, 32'h1234_5678, 16'd0, ref_frame(6'd17, 32'h1234_5678), 1'b1, '0, 48, 0,
            1'b0, 1'b0);
    run_cmd(6'd17, 32'h89AB_CDEF, 16'd1, ref_frame(6'd17, 32'h89AB_CDEF), 1'b1, '0, 48, 0,
            1'b0, 1'b1);
    repeat (3) tick();
    @(negedge clk);
    rstn = 1'b1;
    repeat (20) tick();
    check("no_done_after_abort", 64'(bus.busy), 64'd0);

    // Recovery after reset.
    exp_q.push_back(mk_exp(1'b0, 1'b0, 32'h0000_01AA));
    run_cmd(6'd8, 32'h0000_01AA, 16'd0, 48'h48_0000_01AA_87, 1'b0,
            {88'd0, 48'h08_0000_01AA_13}, 48, 1, 1'b0, 1'b0);

    repeat (10) tick();
    check("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sd_cmd_ctrl.md
Name: sd_cmd_ctrl

Overview:
SD-bus CMD-line engine and SDCLK generator that sits directly upstream of sd_reader. It accepts one command request at a time over the start/busy/done handshake, drives a 48-bit command frame with CRC7, and receives the card's R1/R3/R6/R7 (48-bit) or R2 (136-bit) response. It returns a timeout flag, a syntax-error flag and a 32-bit response argument. The same instance is shared by the sector writer, so there is a single CMD-line driver in the system.

Parameters:
RESP_TIMEOUT, 250, number of SDCLK cycles to wait for a response start bit before declaring timeout
NORESP_GAP, 8, SDCLK cycles idled after a no-response command (CMD0) before done

Ports:
clk  input  1  system clock
rstn  input  1  asynchronous active-low reset
clkdiv  input  16  SDCLK half-period in clk cycles; 0 is treated as 1
start  input  1  one-cycle command request, accepted only when busy=0
precnt  input  16  SDCLK cycles of idle-high CMD driven before the frame
cmd  input  6  command index
arg  input  32  command argument
busy  output  1  transaction in progress
done  output  1  one-cycle completion pulse, asserted while busy=1
timeout  output  1  no response start bit within RESP_TIMEOUT; valid with done
syntaxe  output  1  response format, index or CRC error; valid with done
resparg  output  32  response bits [39:8] (48-bit types); 0 for R2 and no-response; valid with done
sdclk  output  1  SD clock to the card
sdcmd_o  output  1  CMD line output value
sdcmd_oe  output  1  CMD line output enable; top-level tri-state is built from sdcmd_o/sdcmd_oe
sdcmd_i  input  1  CMD line sampled value

Behaviour:
- Reset is rstn, asynchronous, active-low; clock is clk. Reset values: busy=0, done=0, timeout=0, syntaxe=0, resparg=0, sdclk=0, sdcmd_oe=0, sdcmd_o=1, FSM=IDLE. Reset mid-transaction aborts immediately; no done is produced.
- SDCLK generation:
  - A free-running counter toggles sdclk when it reaches max(clkdiv,1)-1, then wraps to 0. SDCLK period = 2*max(clkdiv,1) clk cycles.
  - A new clkdiv value takes effect at the next wrap.
  - "Fall event" = the clk cycle in which sdclk toggles 1->0; "rise event" = the cycle in which it toggles 0->1.
  - sdcmd_o and sdcmd_oe change only on fall events. sdcmd_i is sampled only on rise events.
- Handshake:
  - When start=1 and busy=0, latch precnt, cmd and arg; busy=1 from the next cycle.
  - start is ignored while busy=1.
  - done is a single-cycle pulse with busy still 1; busy=0 in the following cycle.
  - timeout, syntaxe and resparg update in the done cycle and hold until the next done.
- FSM states and transitions:
  - IDLE: oe=0. On accepted start -> PRE.
  - PRE: oe=1, o=1 for precnt fall events (precnt=0 skips to TX).
  - TX: 48 bits MSB first, one per fall event. Frame = '0', '1', cmd[5:0], arg[31:0], crc7[6:0], '1'.
    - CRC7 polynomial x^7+x^3+1, initial value 0, computed over the first 40 bits.
    - After the end bit: if cmd==0 -> GAP, else -> WAIT. oe drops to 0 at the next fall event.
  - GAP: NORESP_GAP SDCLK cycles -> DONE with timeout=0, syntaxe=0, resparg=0.
  - WAIT: count rise events with sdcmd_i=1. The first sample of 0 -> RX (this sample is bit 47/135). If the count reaches RESP_TIMEOUT -> DONE with timeout=1, syntaxe=0, resparg=0.
  - RX: shift in the remaining bits on rise events.
    - Length is 136 if cmd==2, else 48.
    - After the last bit -> DONE.
  - DONE: pulse done for one cycle -> IDLE.
- syntaxe rules, evaluated at DONE after RX:
  - All types: end bit != 1, or transmission bit (second bit) != 0.
  - cmd==41 (R3): no further checks; index and CRC fields are 1s by definition.
  - cmd==2 (R2): only the end bit and transmission bit are checked.
  - All others: received index != cmd, or received CRC7 over the first 40 bits != bits [7:1].
- Timing boundary: a response start bit may arrive on the first rise event after oe drops; WAIT must sample it (Ncr=0 allowed).

Test Plan:
- clkdiv=4, idle: sdclk period 8 clk, 50% duty; change clkdiv to 2 mid-run -> period 4 takes effect after the current half-period.
- start cmd=0, arg=0, precnt=2: 2 SDCLK high, then frame bytes 40 00 00 00 00 95; done after 8 gap SDCLKs with timeout=0, syntaxe=0, resparg=0.
- cmd=8, arg=0x1AA: frame 48 00 00 01 AA 87; card model replies 08 00 00 01 AA 13 -> done, timeout=0, syntaxe=0, resparg=0x000001AA.
- cmd=8, card silent: done exactly 250 rise events after oe drop, timeout=1; same reply with one CRC bit flipped -> syntaxe=1.
- cmd=41 reply 3F C0 FF 80 00 FF -> syntaxe=0, resparg=0xC0FF8000; cmd=2 with 136-bit reply -> syntaxe=0, resparg=0.
- start pulsed while busy is ignored (one done only); rstn asserted mid-TX -> all outputs return to reset values immediately, no done.
